// File: rtl/fpu_issue.sv
// fpu_issue: queues decoded FP instructions, reads operands from the FP
// register file, hands one operation at a time to the FPU and retires the
// result into the register file or the condition flag.
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 5
`endif

module fpu_issue #(
  parameter int unsigned     OP_W    = `FPU_OP_WIDTH,
  parameter int unsigned     TIMEOUT = 31,
  parameter logic [OP_W-1:0] OP_FCLT = OP_W'(6),
  parameter logic [OP_W-1:0] OP_FCZ  = OP_W'(7)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [4:0]      req_rd,
  output logic [OP_W-1:0] fpu_operation,
  output logic [31:0]     fpu_x1,
  output logic [31:0]     fpu_x2,
  output logic            fpu_ready,
  input  logic            fpu_valid,
  input  logic [31:0]     fpu_y32,
  input  logic            fpu_y1,
  input  logic            ext_we,
  input  logic [4:0]      ext_waddr,
  input  logic [31:0]     ext_wdata,
  input  logic [4:0]      dbg_raddr,
  output logic [31:0]     dbg_rdata,
  output logic            cond,
  output logic            done,
  output logic            busy,
  output logic            timeout_err
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  state_t      state;
  req_t        q0;
  req_t        q1;
  req_t        req_new;
  logic [1:0]  cnt;
  logic [31:0] rf [32];
  logic [4:0]  rd_q;
  logic [31:0] y32_q;
  logic        y1_q;
  logic [TW-1:0] tcnt;
  logic        push;
  logic        pop;
  logic        is_cmp;
  logic        wb_we;

  assign req_new   = '{op: req_op, rs1: req_rs1, rs2: req_rs2, rd: req_rd};
  assign req_ready = (cnt != 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && (cnt != 2'd0);
  assign busy      = (state != S_IDLE) || (cnt != 2'd0);
  assign dbg_rdata = rf[dbg_raddr];
  assign is_cmp    = (fpu_operation == OP_FCLT) || (fpu_operation == OP_FCZ);
  assign wb_we     = (state == S_WB) && !is_cmp;

  // Two-entry request FIFO; head always sits in q0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      q0  <= '0;
      q1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) q0 <= req_new;
          else             q1 <= req_new;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: q0 <= req_new;  // only possible with one entry: count unchanged
        default: ;
      endcase
    end
  end

  // Issue FSM: pop, hold operands while the FPU works, then retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      fpu_ready     <= 1'b0;
      fpu_operation <= '0;
      fpu_x1        <= '0;
      fpu_x2        <= '0;
      rd_q          <= '0;
      y32_q         <= '0;
      y1_q          <= 1'b0;
      tcnt          <= '0;
      done          <= 1'b0;
      cond          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cnt != 2'd0) begin
            fpu_operation <= q0.op;
            fpu_x1        <= rf[q0.rs1];
            fpu_x2        <= rf[q0.rs2];
            rd_q          <= q0.rd;
            fpu_ready     <= 1'b1;
            tcnt          <= '0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (fpu_valid) begin
            y32_q     <= fpu_y32;
            y1_q      <= fpu_y1;
            tcnt      <= '0;
            fpu_ready <= 1'b0;
            done      <= 1'b1;
            state     <= S_WB;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // FPU never answered: drop the operation without retiring it.
            timeout_err <= 1'b1;
            fpu_ready   <= 1'b0;
            tcnt        <= '0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WB: begin
          if (is_cmp) cond <= y1_q;
          state <= S_IDLE;
        end
        default: begin
          fpu_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: external port first so a same-address writeback wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (ext_we) rf[ext_waddr] <= ext_wdata;
      if (wb_we)  rf[rd_q]      <= y32_q;
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed plus randomized checks of fpu_issue against an
// in-order sequential model of the instruction stream and a behavioural FPU.
module tb_fpu_issue;

  localparam int unsigned   OP_W = 5;
  localparam logic [4:0]    FADD = 5'd0;
  localparam logic [4:0]    FCLT = 5'd6;
  localparam logic [4:0]    FCZ  = 5'd7;

  typedef struct packed {
    logic [4:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  fpu_operation;
  logic [31:0] fpu_x1;
  logic [31:0] fpu_x2;
  logic        fpu_ready;
  logic        fpu_valid = 1'b0;
  logic [31:0] fpu_y32 = '0;
  logic        fpu_y1 = 1'b0;
  logic        ext_we = 1'b0;
  logic [4:0]  ext_waddr = '0;
  logic [31:0] ext_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic        cond;
  logic        done;
  logic        busy;
  logic        timeout_err;

  fpu_issue #(.OP_W(OP_W), .TIMEOUT(31), .OP_FCLT(FCLT), .OP_FCZ(FCZ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
    .fpu_ready(fpu_ready), .fpu_valid(fpu_valid), .fpu_y32(fpu_y32), .fpu_y1(fpu_y1),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .cond(cond), .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] rf_m [32];
  logic        cond_m = 1'b0;
  logic [68:0] exp_q [$];
  logic [68:0] obs_q [$];
  op_t         pend [$];

  // Behavioural FPU controls and observations
  bit          fpu_hang = 1'b0;
  bit          lat_rand = 1'b0;
  int          lat_fixed = 1;
  bit          y_force_en = 1'b0;
  logic [31:0] y_force = '0;
  int          cyc = 0;
  int          cur_lat = 1;
  int          last_run = 0;
  int          ready_after_valid = 0;
  int          stable_viol = 0;
  int          done_cnt = 0;
  bit          prev_valid = 1'b0;
  bit          saw_full = 1'b0;
  logic [68:0] held = '0;

  function automatic logic [31:0] fpu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + 32'(op) + 32'h1;
  endfunction

  function automatic logic fpu_fn1(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == FCLT) ? (a < b) : (a == 32'h0);
  endfunction

  // FPU: answers after cur_lat ready cycles and records what it was asked.
  always @(posedge clk) begin
    #1;
    if (fpu_ready) begin
      if (cyc == 0) begin
        held = {fpu_operation, fpu_x1, fpu_x2};
        obs_q.push_back(held);
      end else if ({fpu_operation, fpu_x1, fpu_x2} !== held) begin
        stable_viol++;
      end
      if (prev_valid) ready_after_valid++;
      cyc++;
      fpu_valid = !fpu_hang && (cyc >= cur_lat);
      if (fpu_valid) begin
        fpu_y32 = y_force_en ? y_force : fpu_fn(fpu_operation, fpu_x1, fpu_x2);
        fpu_y1  = fpu_fn1(fpu_operation, fpu_x1, fpu_x2);
      end
    end else begin
      if (cyc != 0) last_run = cyc;
      cyc = 0;
      fpu_valid = 1'b0;
      cur_lat = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
    end
    prev_valid = fpu_valid;
  end

  // Retirement counter
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write(input logic [4:0] a, input logic [31:0] d);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    tick();
    ext_we = 1'b0;
    rf_m[a] = d;
  endtask

  function automatic void model_exec(input op_t o);
    logic [31:0] a;
    logic [31:0] b;
    a = rf_m[o.rs1];
    b = rf_m[o.rs2];
    exp_q.push_back({o.op, a, b});
    if (o.op == FCLT || o.op == FCZ) cond_m = fpu_fn1(o.op, a, b);
    else rf_m[o.rd] = fpu_fn(o.op, a, b);
  endfunction

  // Offer every pending op, holding req_valid until each is accepted.
  task automatic push_ops();
    int guard = 0;
    bit acc;
    while (pend.size() != 0 && guard < 2000) begin
      req_valid = 1'b1;
      req_op = pend[0].op; req_rs1 = pend[0].rs1; req_rs2 = pend[0].rs2; req_rd = pend[0].rd;
      acc = req_ready;
      tick();
      if (acc) void'(pend.pop_front());
      else saw_full = 1'b1;
      guard++;
    end
    req_valid = 1'b0;
    if (pend.size() != 0) chk("push_budget", 32'(pend.size()), 32'd0);
  endtask

  task automatic push_one(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input bit model);
    op_t o;
    o = '{op: op, rs1: rs1, rs2: rs2, rd: rd};
    if (model) model_exec(o);
    pend.push_back(o);
    push_ops();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) chk("idle_budget", 32'(busy), 32'd0);
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      tick();
      chk($sformatf("%s_f%0d", tag, i), dbg_rdata, rf_m[i]);
    end
  endtask

  task automatic compare_obs(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      logic [68:0] o;
      logic [68:0] e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_op"}, 32'(o[68:64]), 32'(e[68:64]));
      chk({tag, "_x1"}, o[63:32], e[63:32]);
      chk({tag, "_x2"}, o[31:0], e[31:0]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done_flag(input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int base;
    logic [31:0] res_a;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fpu_ready", 32'(fpu_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cond", 32'(cond), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_op", 32'(fpu_operation), 32'd0);
    chk("rst_x1", fpu_x1, 32'd0);
    rst = 1'b0;
    tick();

    // FADD latency: accept, pop, issue, WB, result visible
    ext_write(5'd1, 32'h3F800000);
    ext_write(5'd2, 32'h40000000);
    y_force_en = 1'b1; y_force = 32'h40400000; lat_fixed = 1;
    dbg_raddr = 5'd3;
    req_valid = 1'b1; req_op = FADD; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd3;
    tick();
    req_valid = 1'b0;
    chk("lat_c1_done", 32'(done), 32'd0);
    tick();
    chk("lat_c2_done", 32'(done), 32'd0);
    chk("lat_c2_ready", 32'(fpu_ready), 32'd1);
    chk("lat_c2_x1", fpu_x1, 32'h3F800000);
    chk("lat_c2_x2", fpu_x2, 32'h40000000);
    tick();
    chk("lat_c3_done", 32'(done), 32'd1);
    chk("lat_c3_ready", 32'(fpu_ready), 32'd0);
    tick();
    chk("lat_c4_done", 32'(done), 32'd0);
    chk("lat_c4_rf3", dbg_rdata, 32'h40400000);
    rf_m[3] = 32'h40400000;
    y_force_en = 1'b0;
    obs_q.delete();

    // Compare ops drive cond only
    push_one(FCLT, 5'd1, 5'd2, 5'd4, 1'b1);
    wait_idle(50);
    tick();
    chk("fclt_cond", 32'(cond), 32'(cond_m));
    chk("fclt_cond_is1", 32'(cond), 32'd1);
    push_one(FCZ, 5'd1, 5'd0, 5'd4, 1'b1);
    wait_idle(50);
    tick();
    chk("fcz_cond", 32'(cond), 32'd0);
    check_rf("cmp");
    compare_obs("cmp");

    // Four held requests against a 3-cycle FPU
    lat_fixed = 3; saw_full = 1'b0; base = done_cnt;
    for (int i = 0; i < 4; i++) begin
      op_t o;
      o = '{op: 5'(i + 1), rs1: 5'(i + 1), rs2: 5'(i + 2), rd: 5'(i + 10)};
      model_exec(o);
      pend.push_back(o);
    end
    push_ops();
    chk("q4_saw_full", 32'(saw_full), 32'd1);
    wait_idle(100);
    tick();
    chk("q4_done_cnt", 32'(done_cnt - base), 32'd4);
    compare_obs("q4");

    // Back-to-back RAW on f5
    lat_fixed = 1;
    begin
      op_t a;
      op_t b;
      a = '{op: FADD, rs1: 5'd1, rs2: 5'd2, rd: 5'd5};
      b = '{op: 5'd2, rs1: 5'd5, rs2: 5'd1, rd: 5'd6};
      model_exec(a);
      res_a = rf_m[5];
      model_exec(b);
      pend.push_back(a);
      pend.push_back(b);
    end
    push_ops();
    wait_idle(50);
    tick();
    if (obs_q.size() >= 2) chk("raw_b_x1", obs_q[1][63:32], res_a);
    else chk("raw_obs_count", 32'(obs_q.size()), 32'd2);
    compare_obs("raw");

    // Timeout: FPU never answers
    fpu_hang = 1'b1; base = done_cnt;
    push_one(FADD, 5'd1, 5'd2, 5'd20, 1'b0);
    wait_idle(100);
    tick();
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_run", 32'(last_run), 32'd31);
    chk("to_no_done", 32'(done_cnt - base), 32'd0);
    dbg_raddr = 5'd20;
    tick();
    chk("to_no_write", dbg_rdata, rf_m[20]);
    obs_q.delete();
    fpu_hang = 1'b0;
    push_one(FADD, 5'd3, 5'd4, 5'd21, 1'b1);
    wait_idle(50);
    dbg_raddr = 5'd21;
    tick();
    chk("to_next_op", dbg_rdata, rf_m[21]);
    compare_obs("to");

    // WB and ext_we on the same / different addresses in the WB cycle
    y_force_en = 1'b1; y_force = 32'hAAAAAAAA;
    push_one(FADD, 5'd1, 5'd2, 5'd7, 1'b0);
    wait_done_flag(20);
    ext_we = 1'b1; ext_waddr = 5'd7; ext_wdata = 32'h55555555;
    tick();
    ext_we = 1'b0;
    rf_m[7] = 32'hAAAAAAAA;
    y_force = 32'h12345678;
    push_one(FADD, 5'd1, 5'd2, 5'd8, 1'b0);
    wait_done_flag(20);
    ext_we = 1'b1; ext_waddr = 5'd9; ext_wdata = 32'h0BADF00D;
    tick();
    ext_we = 1'b0;
    rf_m[8] = 32'h12345678; rf_m[9] = 32'h0BADF00D;
    y_force_en = 1'b0;
    dbg_raddr = 5'd7; tick();
    chk("coll_f7", dbg_rdata, 32'hAAAAAAAA);
    dbg_raddr = 5'd8; tick();
    chk("coll_f8", dbg_rdata, 32'h12345678);
    dbg_raddr = 5'd9; tick();
    chk("coll_f9", dbg_rdata, 32'h0BADF00D);
    obs_q.delete();

    // Randomized stream against the sequential model
    lat_rand = 1'b1; base = done_cnt;
    for (int i = 0; i < 32; i++) ext_write(5'(i), $urandom);
    for (int i = 0; i < 24; i++) begin
      op_t o;
      o = '{op: 5'($urandom_range(0, 7)), rs1: 5'($urandom), rs2: 5'($urandom), rd: 5'($urandom)};
      model_exec(o);
      pend.push_back(o);
    end
    push_ops();
    wait_idle(400);
    tick();
    chk("rnd_done_cnt", 32'(done_cnt - base), 32'd24);
    chk("rnd_cond", 32'(cond), 32'(cond_m));
    compare_obs("rnd");
    check_rf("rnd");
    lat_rand = 1'b0;
    chk("ready_after_valid", 32'(ready_after_valid), 32'd0);
    chk("operand_stable", 32'(stable_viol), 32'd0);

    // Reset during ISSUE with a second op queued
    fpu_hang = 1'b1;
    pend.push_back('{op: FADD, rs1: 5'd1, rs2: 5'd2, rd: 5'd3});
    pend.push_back('{op: FADD, rs1: 5'd2, rs2: 5'd3, rd: 5'd4});
    push_ops();
    begin
      int n = 0;
      while (!fpu_ready && n < 20) begin tick(); n++; end
    end
    chk("mid_ready_before", 32'(fpu_ready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fpu_hang = 1'b0;
    chk("mid_rst_ready", 32'(fpu_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_terr", 32'(timeout_err), 32'd0);
    chk("mid_rst_cond", 32'(cond), 32'd0);
    chk("mid_rst_x1", fpu_x1, 32'd0);
    dbg_raddr = 5'd1;
    tick();
    chk("mid_rst_rf1", dbg_rdata, 32'd0);
    repeat (3) tick();
    chk("mid_rst_queue_empty", 32'(busy), 32'd0);
    chk("mid_rst_no_issue", 32'(fpu_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
